// File: rtl/adder_subtractor_serial.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle, LSB slice first.
// Define OVERFLOW_FLAG_EN to add the signed-overflow output v.
module adder_subtractor_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] g,
  output logic             co
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             v
`endif
);

  localparam int unsigned DigitSafe = (DIGIT == 0) ? 1 : DIGIT;
  localparam int unsigned N         = WIDTH / DigitSafe;
  localparam int unsigned CntW      = (N > 1) ? $clog2(N) : 1;

  if ((DIGIT == 0) || ((WIDTH % DigitSafe) != 0)) begin : g_bad_param
    $error("adder_subtractor_serial: WIDTH must be a multiple of DIGIT and DIGIT >= 1");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, g_q, g_d;
  logic             carry_q, carry_d, co_q, co_d;
  logic             capture, last_slice;
  logic [DIGIT:0]   slice_sum;

  // Operands may only be taken when no operation is in flight.
  assign capture    = start && ((state_q == StIdle) || (state_q == StDone));
  assign last_slice = (cnt_q == CntW'(N - 1));
  assign slice_sum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, carry_q};

`ifdef OVERFLOW_FLAG_EN
  logic v_q, v_d;
  logic msb_cin;
  // Carry into the MSB recovered from the last slice's top sum bit.
  assign msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice_sum[DIGIT-1];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    g_d     = g_q;
    co_d    = co_q;
`ifdef OVERFLOW_FLAG_EN
    v_d     = v_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (capture) state_d = StRun;
      end
      StRun: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = (acc_q >> DIGIT) | (WIDTH'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
        carry_d = slice_sum[DIGIT];
        cnt_d   = cnt_q + CntW'(1);
        if (last_slice) begin
          state_d = StDone;
          cnt_d   = '0;
          g_d     = acc_d;
          co_d    = slice_sum[DIGIT];
`ifdef OVERFLOW_FLAG_EN
          v_d     = msb_cin ^ slice_sum[DIGIT];
`endif
        end
      end
      StDone: begin
        state_d = capture ? StRun : StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Subtraction is a + ~b + ~ci, so invert b and the carry-in at capture.
    if (capture) begin
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = ci ^ sub;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      g_q     <= '0;
      co_q    <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      g_q     <= g_d;
      co_q    <= co_d;
`ifdef OVERFLOW_FLAG_EN
      v_q     <= v_d;
`endif
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign g    = g_q;
  assign co   = co_q;
`ifdef OVERFLOW_FLAG_EN
  assign v    = v_q;
`endif

endmodule

// File: doc/adder_subtractor_serial.md
ADDER_SUBTRACTOR_SERIAL -- requirements
Module: adder_subtractor_serial

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits.
REQ-002 Parameter DIGIT, default 1, bits processed per clock cycle.
REQ-003 clk  input  1  sole clock, rising-edge active.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin an operation with the current a, b, ci, sub.
REQ-006 a  input  WIDTH  first operand.
REQ-007 b  input  WIDTH  second operand.
REQ-008 ci  input  1  carry-in (sub=0) or borrow-in (sub=1).
REQ-009 sub  input  1  0 = add, 1 = subtract.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse marking g/co valid.
REQ-012 g  output  WIDTH  result.
REQ-013 co  output  1  carry-out (add), not-borrow (subtract).
REQ-014 v  output  1  signed overflow; present only under OVERFLOW_FLAG_EN.

Function
REQ-015 WIDTH SHALL be an integer multiple of DIGIT, DIGIT >= 1; otherwise elaboration SHALL fail with an error.
REQ-016 N = WIDTH/DIGIT; the block SHALL use a state machine IDLE -> RUN -> DONE.
REQ-017 IDLE: start=1 at a rising edge captures a, b, ci, sub into internal registers and enters RUN; start=0 stays IDLE.
REQ-018 RUN: each cycle processes one DIGIT-bit slice, LSB slice first, carry propagated between slices via a 1-bit carry register; after N slices enters DONE.
REQ-019 DONE: done=1 for exactly one cycle; g/co (and v) update at the edge entering DONE; next state IDLE, or RUN if start=1 (back-to-back, operands captured).
REQ-020 start in RUN SHALL be ignored; input changes after capture SHALL not affect the running operation.
REQ-021 Latency: done asserted N cycles after the edge that sampled start; throughput one operation per N+1 cycles.
REQ-022 busy=1 exactly when state is RUN.
REQ-023 sub=0: {co,g} = a + b + ci, (WIDTH+1)-bit unsigned.
REQ-024 sub=1: {co,g} = a + ~b + ~ci, i.e. g = a - b - ci modulo 2^WIDTH, co=1 iff no borrow.
REQ-025 g, co, v SHALL hold their last value between done pulses.
REQ-026 The carry register SHALL be initialised from ci (sub=0) or ~ci (sub=1) at capture.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, g=0, co=0, v=0, clearing internal registers.
REQ-028 Reset during RUN SHALL abort the operation with no done pulse; first start after release behaves as from power-up.

Configuration
REQ-029 Macro OVERFLOW_FLAG_EN: defined -> port v exists and is set at DONE to (MSB carry-in XOR MSB carry-out) of the operation; undefined -> port v and its logic are absent, all other behaviour identical.

Verification
REQ-030 WIDTH=8, DIGIT=2: a=0x5A, b=0x33, ci=0, sub=0, start 1 cycle -> busy 4 cycles, done 4 cycles after start edge, g=0x8D, co=0.
REQ-031 WIDTH=8, DIGIT=2: a=0x10, b=0x01, ci=0, sub=1 -> g=0x0F, co=1; a=0x00, b=0x01 -> g=0xFF, co=0.
REQ-032 WIDTH=8, DIGIT=1: a=0x05, b=0x02, ci=1, sub=1 -> g=0x02, co=1, done 8 cycles after start.
REQ-033 OVERFLOW_FLAG_EN defined, WIDTH=8: a=0x7F, b=0x01, ci=0, sub=0 -> g=0x80, co=0, v=1; a=0x01, b=0x01 -> v=0.
REQ-034 start held high continuously with changing operands -> one operation per N+1 cycles, start/operand changes in RUN ignored, results match operands present at each capture edge.
REQ-035 rst_n pulsed low mid-RUN -> outputs 0 immediately, no done; next operation a=0xFF, b=0x01, sub=0 -> g=0x00, co=1.
